// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_step.sv
// rtl/seq_divider_step.sv - one restoring division step on magnitudes
module seq_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The top bit of trial is the borrow: rem < dvs keeps the shifted value within WIDTH+1 bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - start/valid restoring divider, one quotient bit per clock
// SEQ_DIVIDER_SIGNED_EN selects two's-complement operands (truncation toward zero).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             Busy,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Result_Valid,
    output logic             Div_Zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_reg;
    logic             dz;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        abs_a = in_a[WIDTH-1] ? -in_a : in_a;
        abs_b = in_b[WIDTH-1] ? -in_b : in_b;
        q_fix = neg_q ? -quo : quo;
        r_fix = neg_r ? -rem : rem;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == ST_IDLE && in_start) begin
            neg_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            neg_r <= in_a[WIDTH-1];
        end
    end
`else
    always_comb begin
        abs_a = in_a;
        abs_b = in_b;
        q_fix = quo;
        r_fix = rem;
    end
`endif

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign Busy = (state != ST_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            dvs          <= '0;
            a_reg        <= '0;
            dz           <= 1'b0;
            Quotient     <= '0;
            Remainder    <= '0;
            Result_Valid <= 1'b0;
            Div_Zero     <= 1'b0;
        end else begin
            Result_Valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        a_reg <= in_a;
                        dvs   <= abs_b;
                        dz    <= (in_b == '0);
                        rem   <= '0;
                        quo   <= abs_a;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // A zero divisor still runs every step so latency never depends on operands.
                    Quotient     <= dz ? WIDTH'(DIV_ZERO_QUO) : q_fix;
                    Remainder    <= dz ? a_reg : r_fix;
                    Div_Zero     <= dz;
                    Result_Valid <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         in_start = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         Busy;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Result_Valid;
    logic         Div_Zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    seq_divider dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_start     (in_start),
        .in_a         (in_a),
        .in_b         (in_b),
        .Busy         (Busy),
        .Quotient     (Quotient),
        .Remainder    (Remainder),
        .Result_Valid (Result_Valid),
        .Div_Zero     (Div_Zero)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every Result_Valid pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (Result_Valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("quotient", Quotient, e.q);
                check("remainder", Remainder, e.r);
                check("div_zero", {31'b0, Div_Zero}, {31'b0, e.dz});
                check("latency", cyc, e.at);
            end
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] q, input logic [31:0] r, input logic dz,
                         output int accepted);
        exp_t x;
        @(negedge CLK);
        in_a = a;
        in_b = b;
        in_start = 1'b1;
        @(posedge CLK);
        #1;
        in_start = 1'b0;
        accepted = cyc;
        if (push) begin
            x.q = q;
            x.r = r;
            x.dz = dz;
            x.at = accepted + LAT;
            sb.push_back(x);
        end
    endtask

    task automatic wait_done();
        repeat (40) @(negedge CLK);
    endtask

    initial begin
        #1;
        check("reset_quotient", Quotient, 32'h0);
        check("reset_remainder", Remainder, 32'h0);
        check("reset_valid", {31'b0, Result_Valid}, 32'h0);
        check("reset_busy", {31'b0, Busy}, 32'h0);
        check("reset_div_zero", {31'b0, Div_Zero}, 32'h0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Basic 100 / 7 with Busy window checks.
        start(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, acc);
        check("busy_after_accept", {31'b0, Busy}, 32'h1);
        while (cyc < acc + W) @(negedge CLK);
        check("busy_last_calc", {31'b0, Busy}, 32'h1);
        @(negedge CLK);
        check("busy_at_result", {31'b0, Busy}, 32'h0);
        wait_done();

`ifdef SEQ_DIVIDER_SIGNED_EN
        start(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, acc);
        wait_done();
        start(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, acc);
        wait_done();
`else
        start(32'hFFFFFF9C, 32'd7, 1'b1, 32'h24924916, 32'd2, 1'b0, acc);
        wait_done();
        start(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0, acc);
        wait_done();
`endif

        start(32'd123, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd123, 1'b1, acc);
        wait_done();

        // A start pulse while busy must neither re-sample operands nor queue a second run.
        start(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, acc);
        while (cyc < acc + 4) @(negedge CLK);
        in_a = 32'd999;
        in_b = 32'd3;
        in_start = 1'b1;
        @(posedge CLK);
        #1;
        in_start = 1'b0;
        wait_done();

        // Abort mid-operation: outputs clear and no result is produced.
        start(32'd200, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, acc);
        while (cyc < acc + 10) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("abort_quotient", Quotient, 32'h0);
        check("abort_remainder", Remainder, 32'h0);
        check("abort_valid", {31'b0, Result_Valid}, 32'h0);
        check("abort_busy", {31'b0, Busy}, 32'h0);
        check("abort_div_zero", {31'b0, Div_Zero}, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        wait_done();

        start(32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0, acc);
        wait_done();

        check("scoreboard_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider producing quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. It is the inverse-operation companion of the team's shift-add Booth multiplier and sits beside it in the arithmetic lab datapath. It is driven by a start/valid handshake instead of a free-running counter, so operands can be issued on demand.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_start  input  1  request; sampled only in IDLE.
- in_a  input  WIDTH  dividend.
- in_b  input  WIDTH  divisor.
- Busy  output  1  high from accept edge until the result edge.
- Quotient  output  WIDTH  registered quotient; holds until next result.
- Remainder  output  WIDTH  registered remainder; holds until next result.
- Result_Valid  output  1  one-cycle pulse when Quotient/Remainder update.
- Div_Zero  output  1  registered with result; 1 if divisor was zero.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on in_start=1, latch in_a, in_b, operand signs, and the zero-divisor flag; load the remainder register with 0 and the quotient register with |dividend|; clear the iteration count; go to CALC.
- CALC: one restoring step per cycle:
  - shift {rem, quo} left 1;
  - trial = rem − |divisor|, computed at WIDTH+1 bits;
  - if trial is non-negative, rem = trial and the quotient LSB = 1; else the quotient LSB = 0.
  - After WIDTH steps, go to FIX.
- FIX: negate the quotient if the operand signs differ; the remainder takes the dividend's sign; register the outputs; assert Result_Valid; go to IDLE.
- Divisor zero: iterations still run (constant latency). FIX forces Quotient = all ones, Remainder = original in_a, Div_Zero = 1.
- Overflow (signed build): most-negative ÷ −1 gives Quotient = 0x80000000, Remainder = 0, Div_Zero = 0. No trap.
- in_start while Busy: ignored. Operands are not re-sampled.
- Result_Valid and Div_Zero describe the most recent result only. Div_Zero holds with Quotient.
- Reset values: Quotient = 0, Remainder = 0, Result_Valid = 0, Busy = 0, Div_Zero = 0; state = IDLE.
- Reset mid-operation: aborts. No Result_Valid, and the outputs return to 0.

## Timing
- Accept at edge N (IDLE, in_start=1). Busy = 1 after N.
- CALC occupies edges N+1 … N+WIDTH.
- FIX at edge N+WIDTH+1 (N+33 at default): outputs update, Result_Valid = 1 for exactly that cycle, Busy = 0.
- Earliest next accept is edge N+WIDTH+2, giving a throughput of one division per WIDTH+2 cycles.
- Latency is independent of operand values, including a zero divisor.

## Configuration
- SEQ_DIVIDER_SIGNED_EN:
  - Defined: operands are two's complement; the magnitude algorithm is wrapped by input abs and FIX sign correction; truncation is toward zero.
  - Undefined: operands are unsigned, abs/negation logic is removed, and FIX only registers the result.
  - Latency is identical in both builds.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - the default width constant (32);
  - the iteration-counter width, clog2(WIDTH+1);
  - the all-ones quotient constant for divide-by-zero.
- One combinational sub-module, seq_divider_step: takes rem, quo and divisor magnitude and returns the next rem/quo. It is instantiated once, and the top level holds the FSM, counter and sign fix.

## Test plan
- Unsigned-valued basic: a=100, b=7, start at edge N. Required: Result_Valid only at N+33; Quotient=14, Remainder=2; Busy high N+1…N+32.
- Signed build: a=−100 (0xFFFFFF9C), b=7. Required: Quotient=0xFFFFFFF2 (−14), Remainder=0xFFFFFFFE (−2).
- Unsigned build, same operands: Quotient=0x24924916, Remainder=2.
- Divide by zero: a=123, b=0. Required: Quotient=0xFFFFFFFF, Remainder=123, Div_Zero=1, still at N+33.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF. Required: Quotient=0x80000000, Remainder=0, Div_Zero=0.
- Start while busy, then reset mid-operation:
  - in_start pulses at N+5 with new operands: ignored, the first result is unchanged.
  - A second run with RST asserted at N+10: all outputs 0, no Result_Valid pulse, the next start after release is accepted normally.
